alu_cdb: RTL and testbench

Common-data-bus arbiter on the result side of the ALU reservation station. It buffers results from the ALU and from the load/store buffer in per-source FIFOs and broadcasts at most one result per cycle back to the reservation stations. For ALU results it also returns the RS slot to free, and for jumps it drives the PC redirect to the fetcher. It is the consumer of the ALU's `aluSignal`/`ALU_CDB_out_*` outputs and the producer of its `aluFinish`/`ALU_CDB_*` inputs.

---
 rtl/alu_cdb.sv | 199 +++++++++++++++++++
 tb/tb_alu_cdb.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cdb.sv
// alu_cdb: common-data-bus arbiter for the ALU reservation station.
// Buffers ALU results and load/store-buffer results in two circular FIFOs
// and broadcasts at most one result per cycle on registered outputs.
// ALU broadcasts also return the RS slot to free. Jumps additionally pulse
// a registered PC redirect toward the fetcher.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   mispredictionRst       synchronous flush of both FIFOs and the bus
//   aluSignal, ALU_CDB_out_*, ALU_CDB_PC_valid   ALU result input
//   alu_stall              ALU FIFO full (combinational)
//   LSBuf_out_*            load result input
//   lsb_stall              LSB FIFO full (combinational)
//   aluFinish, ALU_CDB_*   ALU-sourced broadcast
//   LSBuf_CDB_*            LSB-sourced broadcast
//   pc_redirect_*          one-cycle jump redirect
//   overflow               sticky: a push arrived while its FIFO was full
// The width parameters and tagFree mirror the shared core definitions.
module alu_cdb #(
    parameter int FIFO_DEPTH = 4,
    parameter int tagWidth   = 5,
    parameter int dataWidth  = 32,
    parameter int addrWidth  = 32,
    parameter int aluRSWidth = 3,
    parameter logic [tagWidth-1:0] tagFree = {tagWidth{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mispredictionRst,
    input  logic                  aluSignal,
    input  logic [aluRSWidth-1:0] ALU_CDB_out_RSnum,
    input  logic [tagWidth-1:0]   ALU_CDB_out_tag,
    input  logic [dataWidth-1:0]  ALU_CDB_out_data,
    input  logic [addrWidth-1:0]  ALU_CDB_out_offset,
    input  logic                  ALU_CDB_PC_valid,
    output logic                  alu_stall,
    input  logic                  LSBuf_out_valid,
    input  logic [tagWidth-1:0]   LSBuf_out_tag,
    input  logic [dataWidth-1:0]  LSBuf_out_data,
    output logic                  lsb_stall,
    output logic                  aluFinish,
    output logic [aluRSWidth-1:0] ALU_CDB_RSnum,
    output logic [tagWidth-1:0]   ALU_CDB_tag,
    output logic [dataWidth-1:0]  ALU_CDB_data,
    output logic                  LSBuf_CDB_valid,
    output logic [tagWidth-1:0]   LSBuf_CDB_tag,
    output logic [dataWidth-1:0]  LSBuf_CDB_data,
    output logic                  pc_redirect_valid,
    output logic [addrWidth-1:0]  pc_redirect_target,
    output logic                  overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int AE_W  = aluRSWidth + tagWidth + dataWidth + addrWidth + 1;
    localparam int LE_W  = tagWidth + dataWidth;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

    typedef enum logic {GRANT_LSB = 1'b0, GRANT_ALU = 1'b1} grant_t;

    logic [AE_W-1:0]  alu_mem [FIFO_DEPTH];
    logic [LE_W-1:0]  lsb_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] alu_rd_ptr_r, alu_wr_ptr_r, lsb_rd_ptr_r, lsb_wr_ptr_r;
    logic [CNT_W-1:0] alu_count_r, lsb_count_r;
    grant_t           last_grant_r;

    logic alu_full_s, alu_empty_s, lsb_full_s, lsb_empty_s;
    logic alu_push_s, lsb_push_s, alu_pop_s, lsb_pop_s, ovf_set_s;
    logic [AE_W-1:0]       alu_in_s;
    logic [LE_W-1:0]       lsb_in_s;
    logic [aluRSWidth-1:0] alu_head_rsnum_s;
    logic [tagWidth-1:0]   alu_head_tag_s, lsb_head_tag_s;
    logic [dataWidth-1:0]  alu_head_data_s, lsb_head_data_s;
    logic [addrWidth-1:0]  alu_head_offset_s;
    logic                  alu_head_pcv_s;

    // Full checks use the pre-edge count, so a same-edge pop never makes
    // room for a same-edge push into a full FIFO.
    assign alu_full_s  = (alu_count_r == FULL_CNT);
    assign lsb_full_s  = (lsb_count_r == FULL_CNT);
    assign alu_empty_s = (alu_count_r == ZERO_CNT);
    assign lsb_empty_s = (lsb_count_r == ZERO_CNT);
    assign alu_stall   = alu_full_s;
    assign lsb_stall   = lsb_full_s;

    // Flush outranks every push and pop.
    assign alu_push_s = aluSignal & ~alu_full_s & ~mispredictionRst;
    assign lsb_push_s = LSBuf_out_valid & ~lsb_full_s & ~mispredictionRst;

    // ALU wins when alone or when LSB was granted last (round-robin tie).
    assign alu_pop_s = ~alu_empty_s & ~mispredictionRst &
                       (lsb_empty_s | (last_grant_r == GRANT_LSB));
    assign lsb_pop_s = ~lsb_empty_s & ~mispredictionRst & ~alu_pop_s;

    assign ovf_set_s = ~mispredictionRst &
                       ((aluSignal & alu_full_s) | (LSBuf_out_valid & lsb_full_s));

    assign alu_in_s = {ALU_CDB_out_RSnum, ALU_CDB_out_tag, ALU_CDB_out_data,
                       ALU_CDB_out_offset, ALU_CDB_PC_valid};
    assign lsb_in_s = {LSBuf_out_tag, LSBuf_out_data};

    assign {alu_head_rsnum_s, alu_head_tag_s, alu_head_data_s,
            alu_head_offset_s, alu_head_pcv_s} = alu_mem[alu_rd_ptr_r];
    assign {lsb_head_tag_s, lsb_head_data_s} = lsb_mem[lsb_rd_ptr_r];

    // FIFO storage; entries beyond the count are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (alu_push_s) begin
            alu_mem[alu_wr_ptr_r] <= alu_in_s;
        end
        if (lsb_push_s) begin
            lsb_mem[lsb_wr_ptr_r] <= lsb_in_s;
        end
    end

    // FIFO pointers and occupancy counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_rd_ptr_r <= {PTR_W{1'b0}};
            alu_wr_ptr_r <= {PTR_W{1'b0}};
            alu_count_r  <= ZERO_CNT;
            lsb_rd_ptr_r <= {PTR_W{1'b0}};
            lsb_wr_ptr_r <= {PTR_W{1'b0}};
            lsb_count_r  <= ZERO_CNT;
        end else if (mispredictionRst) begin
            alu_rd_ptr_r <= {PTR_W{1'b0}};
            alu_wr_ptr_r <= {PTR_W{1'b0}};
            alu_count_r  <= ZERO_CNT;
            lsb_rd_ptr_r <= {PTR_W{1'b0}};
            lsb_wr_ptr_r <= {PTR_W{1'b0}};
            lsb_count_r  <= ZERO_CNT;
        end else begin
            // Power-of-two depth: pointer wrap is the natural overflow.
            if (alu_push_s) alu_wr_ptr_r <= alu_wr_ptr_r + PTR_W'(1);
            if (alu_pop_s)  alu_rd_ptr_r <= alu_rd_ptr_r + PTR_W'(1);
            if (lsb_push_s) lsb_wr_ptr_r <= lsb_wr_ptr_r + PTR_W'(1);
            if (lsb_pop_s)  lsb_rd_ptr_r <= lsb_rd_ptr_r + PTR_W'(1);
            alu_count_r <= alu_count_r + CNT_W'(alu_push_s) - CNT_W'(alu_pop_s);
            lsb_count_r <= lsb_count_r + CNT_W'(lsb_push_s) - CNT_W'(lsb_pop_s);
        end
    end

    // Round-robin history and sticky overflow; both survive a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= GRANT_LSB;
            overflow     <= 1'b0;
        end else begin
            if (alu_pop_s) begin
                last_grant_r <= GRANT_ALU;
            end else if (lsb_pop_s) begin
                last_grant_r <= GRANT_LSB;
            end
            overflow <= overflow | ovf_set_s;
        end
    end

    // Broadcast registers: load the popped entry, otherwise idle values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluFinish          <= 1'b0;
            ALU_CDB_RSnum      <= {aluRSWidth{1'b0}};
            ALU_CDB_tag        <= tagFree;
            ALU_CDB_data       <= {dataWidth{1'b0}};
            LSBuf_CDB_valid    <= 1'b0;
            LSBuf_CDB_tag      <= tagFree;
            LSBuf_CDB_data     <= {dataWidth{1'b0}};
            pc_redirect_valid  <= 1'b0;
            pc_redirect_target <= {addrWidth{1'b0}};
        end else begin
            aluFinish         <= 1'b0;
            ALU_CDB_RSnum     <= {aluRSWidth{1'b0}};
            ALU_CDB_tag       <= tagFree;
            ALU_CDB_data      <= {dataWidth{1'b0}};
            LSBuf_CDB_valid   <= 1'b0;
            LSBuf_CDB_tag     <= tagFree;
            LSBuf_CDB_data    <= {dataWidth{1'b0}};
            pc_redirect_valid <= 1'b0;
            // Pops are already suppressed during a flush, so idle values win.
            if (alu_pop_s) begin
                aluFinish         <= 1'b1;
                ALU_CDB_RSnum     <= alu_head_rsnum_s;
                ALU_CDB_tag       <= alu_head_tag_s;
                ALU_CDB_data      <= alu_head_data_s;
                pc_redirect_valid <= alu_head_pcv_s;
                // Target holds its last value unless a jump is broadcast.
                if (alu_head_pcv_s) begin
                    pc_redirect_target <= alu_head_offset_s;
                end
            end else if (lsb_pop_s) begin
                LSBuf_CDB_valid <= 1'b1;
                LSBuf_CDB_tag   <= lsb_head_tag_s;
                LSBuf_CDB_data  <= lsb_head_data_s;
            end
        end
    end

endmodule

// File: tb/tb_alu_cdb.sv
module tb_alu_cdb;
    localparam int DEPTH = 4;
    localparam int TW = 5;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RW = 3;
    localparam logic [TW-1:0] TFREE = 5'd0;

    logic clk, rst_n, mispredictionRst;
    logic aluSignal, ALU_CDB_PC_valid, alu_stall, LSBuf_out_valid, lsb_stall;
    logic [RW-1:0] ALU_CDB_out_RSnum, ALU_CDB_RSnum;
    logic [TW-1:0] ALU_CDB_out_tag, LSBuf_out_tag, ALU_CDB_tag, LSBuf_CDB_tag;
    logic [DW-1:0] ALU_CDB_out_data, LSBuf_out_data, ALU_CDB_data, LSBuf_CDB_data;
    logic [AW-1:0] ALU_CDB_out_offset, pc_redirect_target;
    logic aluFinish, LSBuf_CDB_valid, pc_redirect_valid, overflow;

    alu_cdb #(.FIFO_DEPTH(DEPTH), .tagWidth(TW), .dataWidth(DW), .addrWidth(AW),
              .aluRSWidth(RW), .tagFree(TFREE)) dut (
        .clk(clk), .rst_n(rst_n), .mispredictionRst(mispredictionRst),
        .aluSignal(aluSignal), .ALU_CDB_out_RSnum(ALU_CDB_out_RSnum),
        .ALU_CDB_out_tag(ALU_CDB_out_tag), .ALU_CDB_out_data(ALU_CDB_out_data),
        .ALU_CDB_out_offset(ALU_CDB_out_offset), .ALU_CDB_PC_valid(ALU_CDB_PC_valid),
        .alu_stall(alu_stall), .LSBuf_out_valid(LSBuf_out_valid),
        .LSBuf_out_tag(LSBuf_out_tag), .LSBuf_out_data(LSBuf_out_data),
        .lsb_stall(lsb_stall), .aluFinish(aluFinish), .ALU_CDB_RSnum(ALU_CDB_RSnum),
        .ALU_CDB_tag(ALU_CDB_tag), .ALU_CDB_data(ALU_CDB_data),
        .LSBuf_CDB_valid(LSBuf_CDB_valid), .LSBuf_CDB_tag(LSBuf_CDB_tag),
        .LSBuf_CDB_data(LSBuf_CDB_data), .pc_redirect_valid(pc_redirect_valid),
        .pc_redirect_target(pc_redirect_target), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (queues) ----------------
    typedef struct {
        logic [RW-1:0] rs; logic [TW-1:0] tag; logic [DW-1:0] data;
        logic [AW-1:0] off; logic pcv;
    } alu_ent_t;
    typedef struct { logic [TW-1:0] tag; logic [DW-1:0] data; } lsb_ent_t;

    alu_ent_t aq[$];
    lsb_ent_t lq[$];
    bit m_last_alu, m_ovf;
    logic e_afin, e_lv, e_redir;
    logic [RW-1:0] e_rs;
    logic [TW-1:0] e_atag, e_ltag;
    logic [DW-1:0] e_adata, e_ldata;
    logic [AW-1:0] e_target;

    int errors = 0;
    int checks = 0;
    bit watch_drop, seen_drop, stalled_seen;
    logic [TW-1:0] drop_tag, ltag_next;
    int valid_seen;

    typedef struct {
        logic rst; logic av; logic [RW-1:0] rs; logic [TW-1:0] at; logic [DW-1:0] ad;
        logic [AW-1:0] off; logic pcv; logic lv; logic [TW-1:0] lt; logic [DW-1:0] ld;
        logic x_af; logic [TW-1:0] x_at; logic [DW-1:0] x_ad; logic [RW-1:0] x_rs;
        logic x_lv; logic [TW-1:0] x_lt; logic x_rd; logic [AW-1:0] x_rt;
    } vec_t;
    vec_t vt[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_idle_bus();
        e_afin = 1'b0; e_rs = '0; e_atag = TFREE; e_adata = '0;
        e_lv = 1'b0; e_ltag = TFREE; e_ldata = '0; e_redir = 1'b0;
    endtask

    task automatic model_reset();
        aq.delete(); lq.delete();
        model_idle_bus();
        e_target = '0; m_last_alu = 1'b0; m_ovf = 1'b0;
    endtask

    // Predict the effect of the coming rising edge from the current inputs.
    task automatic model_edge();
        alu_ent_t a;
        lsb_ent_t l;
        bit a_full, l_full;
        model_idle_bus();
        if (mispredictionRst) begin
            aq.delete(); lq.delete();
        end else begin
            a_full = (aq.size() == DEPTH);
            l_full = (lq.size() == DEPTH);
            if (aq.size() > 0 && (lq.size() == 0 || !m_last_alu)) begin
                a = aq.pop_front();
                e_afin = 1'b1; e_rs = a.rs; e_atag = a.tag; e_adata = a.data;
                m_last_alu = 1'b1;
                if (a.pcv) begin e_redir = 1'b1; e_target = a.off; end
            end else if (lq.size() > 0) begin
                l = lq.pop_front();
                e_lv = 1'b1; e_ltag = l.tag; e_ldata = l.data;
                m_last_alu = 1'b0;
            end
            if (aluSignal) begin
                if (a_full) m_ovf = 1'b1;
                else aq.push_back('{ALU_CDB_out_RSnum, ALU_CDB_out_tag, ALU_CDB_out_data,
                                    ALU_CDB_out_offset, ALU_CDB_PC_valid});
            end
            if (LSBuf_out_valid) begin
                if (l_full) m_ovf = 1'b1;
                else lq.push_back('{LSBuf_out_tag, LSBuf_out_data});
            end
        end
    endtask

    task automatic check_outputs();
        chk("aluFinish", 64'(aluFinish), 64'(e_afin));
        chk("ALU_CDB_RSnum", 64'(ALU_CDB_RSnum), 64'(e_rs));
        chk("ALU_CDB_tag", 64'(ALU_CDB_tag), 64'(e_atag));
        chk("ALU_CDB_data", 64'(ALU_CDB_data), 64'(e_adata));
        chk("LSBuf_CDB_valid", 64'(LSBuf_CDB_valid), 64'(e_lv));
        chk("LSBuf_CDB_tag", 64'(LSBuf_CDB_tag), 64'(e_ltag));
        chk("LSBuf_CDB_data", 64'(LSBuf_CDB_data), 64'(e_ldata));
        chk("pc_redirect_valid", 64'(pc_redirect_valid), 64'(e_redir));
        chk("pc_redirect_target", 64'(pc_redirect_target), 64'(e_target));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("alu_stall", 64'(alu_stall), 64'(aq.size() == DEPTH));
        chk("lsb_stall", 64'(lsb_stall), 64'(lq.size() == DEPTH));
        chk("one_valid", 64'(aluFinish & LSBuf_CDB_valid), 64'd0);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        if (aluFinish || LSBuf_CDB_valid) valid_seen++;
        if (watch_drop && LSBuf_CDB_valid && LSBuf_CDB_tag == drop_tag) seen_drop = 1'b1;
    endtask

    task automatic set_idle();
        aluSignal = 1'b0; ALU_CDB_out_RSnum = '0; ALU_CDB_out_tag = '0;
        ALU_CDB_out_data = '0; ALU_CDB_out_offset = '0; ALU_CDB_PC_valid = 1'b0;
        LSBuf_out_valid = 1'b0; LSBuf_out_tag = '0; LSBuf_out_data = '0;
        mispredictionRst = 1'b0;
    endtask

    task automatic drive_alu(input logic [RW-1:0] rs, input logic [TW-1:0] tag,
                             input logic [DW-1:0] data, input logic [AW-1:0] off,
                             input logic pcv);
        aluSignal = 1'b1; ALU_CDB_out_RSnum = rs; ALU_CDB_out_tag = tag;
        ALU_CDB_out_data = data; ALU_CDB_out_offset = off; ALU_CDB_PC_valid = pcv;
    endtask

    task automatic drive_lsb(input logic [TW-1:0] tag, input logic [DW-1:0] data);
        LSBuf_out_valid = 1'b1; LSBuf_out_tag = tag; LSBuf_out_data = data;
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        set_idle();
        watch_drop = 1'b0; seen_drop = 1'b0; drop_tag = 5'd31; valid_seen = 0;
        model_reset();
        #2;

        // Directed vectors: single result, jump redirect, then contention.
        vt[0]  = '{1'b1,1'b1,3'd2,5'd3,32'd7,32'd0,1'b0,1'b0,5'd0,32'd0, 1'b0,5'd0,32'd0,3'd0,1'b0,5'd0,1'b0,32'd0};
        vt[1]  = '{1'b0,1'b0,3'd0,5'd0,32'd0,32'd0,1'b0,1'b0,5'd0,32'd0, 1'b1,5'd3,32'd7,3'd2,1'b0,5'd0,1'b0,32'd0};
        vt[2]  = '{1'b0,1'b0,3'd0,5'd0,32'd0,32'd0,1'b0,1'b0,5'd0,32'd0, 1'b0,5'd0,32'd0,3'd0,1'b0,5'd0,1'b0,32'd0};
        vt[3]  = '{1'b0,1'b1,3'd1,5'd4,32'd8,32'h1004,1'b1,1'b0,5'd0,32'd0, 1'b0,5'd0,32'd0,3'd0,1'b0,5'd0,1'b0,32'd0};
        vt[4]  = '{1'b0,1'b0,3'd0,5'd0,32'd0,32'd0,1'b0,1'b0,5'd0,32'd0, 1'b1,5'd4,32'd8,3'd1,1'b0,5'd0,1'b1,32'h1004};
        vt[5]  = '{1'b0,1'b0,3'd0,5'd0,32'd0,32'd0,1'b0,1'b0,5'd0,32'd0, 1'b0,5'd0,32'd0,3'd0,1'b0,5'd0,1'b0,32'h1004};
        vt[6]  = '{1'b1,1'b1,3'd0,5'd1,32'd1,32'd0,1'b0,1'b1,5'd9,32'd109, 1'b0,5'd0,32'd0,3'd0,1'b0,5'd0,1'b0,32'd0};
        vt[7]  = '{1'b0,1'b1,3'd0,5'd2,32'd2,32'd0,1'b0,1'b1,5'd10,32'd110, 1'b1,5'd1,32'd1,3'd0,1'b0,5'd0,1'b0,32'd0};
        vt[8]  = '{1'b0,1'b1,3'd0,5'd3,32'd3,32'd0,1'b0,1'b1,5'd11,32'd111, 1'b0,5'd0,32'd0,3'd0,1'b1,5'd9,1'b0,32'd0};
        vt[9]  = '{1'b0,1'b0,3'd0,5'd0,32'd0,32'd0,1'b0,1'b0,5'd0,32'd0, 1'b1,5'd2,32'd2,3'd0,1'b0,5'd0,1'b0,32'd0};
        vt[10] = '{1'b0,1'b0,3'd0,5'd0,32'd0,32'd0,1'b0,1'b0,5'd0,32'd0, 1'b0,5'd0,32'd0,3'd0,1'b1,5'd10,1'b0,32'd0};
        vt[11] = '{1'b0,1'b0,3'd0,5'd0,32'd0,32'd0,1'b0,1'b0,5'd0,32'd0, 1'b1,5'd3,32'd3,3'd0,1'b0,5'd0,1'b0,32'd0};
        vt[12] = '{1'b0,1'b0,3'd0,5'd0,32'd0,32'd0,1'b0,1'b0,5'd0,32'd0, 1'b0,5'd0,32'd0,3'd0,1'b1,5'd11,1'b0,32'd0};
        vt[13] = '{1'b0,1'b0,3'd0,5'd0,32'd0,32'd0,1'b0,1'b0,5'd0,32'd0, 1'b0,5'd0,32'd0,3'd0,1'b0,5'd0,1'b0,32'd0};

        for (int i = 0; i < 14; i++) begin
            if (vt[i].rst) do_reset();
            set_idle();
            if (vt[i].av) drive_alu(vt[i].rs, vt[i].at, vt[i].ad, vt[i].off, vt[i].pcv);
            if (vt[i].lv) drive_lsb(vt[i].lt, vt[i].ld);
            step();
            chk("vec_afin", 64'(aluFinish), 64'(vt[i].x_af));
            chk("vec_atag", 64'(ALU_CDB_tag), 64'(vt[i].x_at));
            chk("vec_adata", 64'(ALU_CDB_data), 64'(vt[i].x_ad));
            chk("vec_rsnum", 64'(ALU_CDB_RSnum), 64'(vt[i].x_rs));
            chk("vec_lvalid", 64'(LSBuf_CDB_valid), 64'(vt[i].x_lv));
            chk("vec_ltag", 64'(LSBuf_CDB_tag), 64'(vt[i].x_lt));
            chk("vec_redir", 64'(pc_redirect_valid), 64'(vt[i].x_rd));
            chk("vec_target", 64'(pc_redirect_target), 64'(vt[i].x_rt));
        end

        // Full and overflow: ALU streams (honouring its stall), LSB fills up.
        do_reset();
        ltag_next = 5'd1; stalled_seen = 1'b0; watch_drop = 1'b1; seen_drop = 1'b0;
        for (int i = 0; i < 30 && !stalled_seen; i++) begin
            set_idle();
            if (!alu_stall) drive_alu(3'd1, TW'(16 + (i % 8)), 32'(i), 32'd0, 1'b0);
            drive_lsb(ltag_next, 32'(200 + i));
            ltag_next = ltag_next + 5'd1;
            step();
            if (lsb_stall) stalled_seen = 1'b1;
        end
        chk("lsb_stall_reached", 64'(stalled_seen), 64'd1);
        chk("lsb_queue_full", 64'(lq.size()), 64'(DEPTH));
        set_idle();
        drive_lsb(drop_tag, 32'hDEAD);
        step();
        chk("overflow_set", 64'(overflow), 64'd1);
        set_idle();
        for (int i = 0; i < 14; i++) step();
        chk("dropped_tag_absent", 64'(seen_drop), 64'd0);
        watch_drop = 1'b0;

        // Flush with entries queued; inputs during the flush are discarded.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_idle();
            drive_alu(3'd2, TW'(1 + i), 32'(i), 32'd0, 1'b0);
            drive_lsb(TW'(5 + i), 32'(50 + i));
            step();
        end
        set_idle();
        mispredictionRst = 1'b1;
        drive_alu(3'd3, 5'd9, 32'd9, 32'd0, 1'b0);
        step();
        chk("flush_afin", 64'(aluFinish), 64'd0);
        chk("flush_alu_stall", 64'(alu_stall), 64'd0);
        chk("flush_lsb_stall", 64'(lsb_stall), 64'd0);
        set_idle();
        valid_seen = 0;
        for (int i = 0; i < 4; i++) step();
        chk("flush_no_broadcast", 64'(valid_seen), 64'd0);
        drive_alu(3'd4, 5'd12, 32'd12, 32'd0, 1'b0);
        step();
        set_idle();
        step();
        chk("post_flush_afin", 64'(aluFinish), 64'd1);
        chk("post_flush_tag", 64'(ALU_CDB_tag), 64'd12);

        // Asynchronous reset in the middle of a broadcast window.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_idle();
            drive_alu(3'd5, TW'(1 + i), 32'(10 + i), 32'h2000, 1'b1);
            drive_lsb(TW'(5 + i), 32'(60 + i));
            step();
        end
        set_idle();
        chk("pre_reset_bcast", 64'(aluFinish | LSBuf_CDB_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        chk("async_afin", 64'(aluFinish), 64'd0);
        chk("async_target", 64'(pc_redirect_target), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        valid_seen = 0;
        for (int i = 0; i < 5; i++) step();
        chk("async_queue_gone", 64'(valid_seen), 64'd0);

        // Randomized traffic against the queue model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            set_idle();
            if ($urandom_range(63) == 0) mispredictionRst = 1'b1;
            if ($urandom_range(1) == 1 && (!alu_stall || $urandom_range(3) == 0))
                drive_alu(RW'($urandom), TW'($urandom), $urandom, $urandom,
                          ($urandom_range(3) == 0));
            if ($urandom_range(1) == 1 && (!lsb_stall || $urandom_range(3) == 0))
                drive_lsb(TW'($urandom), $urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
